seven_seg_scan_driver: RTL

Multiplexed multi-digit seven-segment display driver that time-shares one segment bus across NUM_DIGITS common-anode digits. It decodes 4-bit BCD/hex digits from a double-buffered shadow register and scans the digits at a programmable refresh rate. It adds inter-digit blanking against ghosting, leading-zero suppression and per-digit decimal points. It sits between numeric datapath logic, such as counters and ALUs, and the board display pins.

---
 rtl/seven_seg_scan_driver_if.sv | 25 ++
 rtl/seven_seg_scan_driver.sv | 128 ++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_driver_if.sv
// Display-side bundle for the seven-segment scan driver: datapath inputs and pin outputs.
// The driver attaches through the slave modport; the producer of digit data uses master.
interface seven_seg_scan_driver_if #(
   parameter int NUM_DIGITS = 4
);
   logic                      en;
   logic                      load;
   logic [4*NUM_DIGITS-1:0]   bcd_in;
   logic [NUM_DIGITS-1:0]     dp_in;
   logic                      lz_sup;
   logic [6:0]                seg;
   logic                      dp;
   logic [NUM_DIGITS-1:0]     an;
   logic                      frame_start;

   modport master (
      output en, load, bcd_in, dp_in, lz_sup,
      input  seg, dp, an, frame_start
   );

   modport slave (
      input  en, load, bcd_in, dp_in, lz_sup,
      output seg, dp, an, frame_start
   );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed common-anode seven-segment driver: shadow-buffered digits, per-slot blanking,
// leading-zero suppression and decimal points; all outputs are registered.
module seven_seg_scan_driver #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 2,
   parameter int HEX_EN       = 0
) (
   input logic                   clk,
   input logic                   rst,
   seven_seg_scan_driver_if.slave bus
);
   localparam int PW = $clog2(REFRESH_DIV);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   logic [PW-1:0]             presc_q, presc_d;
   logic [IW-1:0]             idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0]   shadow_q, shadow_d;
   logic [NUM_DIGITS-1:0]     sdp_q, sdp_d;
   logic [6:0]                seg_q, seg_d;
   logic                      dp_q, dp_d;
   logic [NUM_DIGITS-1:0]     an_q, an_d;
   logic                      fs_q, fs_d;

   logic                      presc_wrap;
   logic                      active;
   logic                      zero_above;
   logic                      suppress;
   logic [3:0]                cur_digit;
   logic                      cur_dp;

   function automatic logic [6:0] decode(input logic [3:0] code);
      logic [6:0] s;
      case (code)
         4'h0:    s = 7'b0000001;
         4'h1:    s = 7'b1001111;
         4'h2:    s = 7'b0010010;
         4'h3:    s = 7'b0000110;
         4'h4:    s = 7'b1001100;
         4'h5:    s = 7'b0100100;
         4'h6:    s = 7'b0100000;
         4'h7:    s = 7'b0001111;
         4'h8:    s = 7'b0000000;
         4'h9:    s = 7'b0000100;
         4'hA:    s = (HEX_EN != 0) ? 7'b0001000 : 7'b1111111;
         4'hB:    s = (HEX_EN != 0) ? 7'b1100000 : 7'b1111111;
         4'hC:    s = (HEX_EN != 0) ? 7'b0110001 : 7'b1111111;
         4'hD:    s = (HEX_EN != 0) ? 7'b1000010 : 7'b1111111;
         4'hE:    s = (HEX_EN != 0) ? 7'b0110000 : 7'b1111111;
         4'hF:    s = (HEX_EN != 0) ? 7'b0111000 : 7'b1111111;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   assign presc_wrap = (presc_q == PW'(REFRESH_DIV - 1));
   assign active     = bus.en && !(presc_q < PW'(BLANK_CYCLES));

   always_comb begin
      presc_d = presc_q;
      idx_d   = idx_q;
      if (bus.en) begin
         presc_d = presc_wrap ? '0 : presc_q + 1'b1;
         if (presc_wrap)
            idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end
   end

   assign shadow_d = bus.load ? bus.bcd_in : shadow_q;
   assign sdp_d    = bus.load ? bus.dp_in  : sdp_q;

   // Walk digits from the most significant down so zero_above covers digit k and everything above it.
   always_comb begin
      zero_above = 1'b1;
      suppress   = 1'b0;
      cur_digit  = 4'h0;
      cur_dp     = 1'b0;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         zero_above = zero_above & (shadow_q[4*k +: 4] == 4'h0);
         if (idx_q == IW'(k)) begin
            cur_digit = shadow_q[4*k +: 4];
            cur_dp    = sdp_q[k];
            suppress  = bus.lz_sup && (k != 0) && zero_above;
         end
      end
   end

   always_comb begin
      seg_d = 7'b1111111;
      dp_d  = 1'b1;
      an_d  = '1;
      if (active) begin
         seg_d = suppress ? 7'b1111111 : decode(cur_digit);
         dp_d  = ~cur_dp;
         for (int k = 0; k < NUM_DIGITS; k++)
            an_d[k] = (idx_q != IW'(k));
      end
   end

   assign fs_d = bus.en && (presc_q == '0) && (idx_q == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q  <= '0;
         idx_q    <= '0;
         shadow_q <= '0;
         sdp_q    <= '0;
         seg_q    <= 7'b1111111;
         dp_q     <= 1'b1;
         an_q     <= '1;
         fs_q     <= 1'b0;
      end else begin
         presc_q  <= presc_d;
         idx_q    <= idx_d;
         shadow_q <= shadow_d;
         sdp_q    <= sdp_d;
         seg_q    <= seg_d;
         dp_q     <= dp_d;
         an_q     <= an_d;
         fs_q     <= fs_d;
      end
   end

   assign bus.seg         = seg_q;
   assign bus.dp          = dp_q;
   assign bus.an          = an_q;
   assign bus.frame_start = fs_q;
endmodule
